sch_resp_checker: RTL
=====================

Name: sch_resp_checker

Overview:
- Synthesizable response checker that consumes the outputs of two implementations of the Sch adder/mux datapath (v1 and v2) driven by the same stimulus vector.
- Compares them each accepted cycle, counts vectors and mismatches, and latches the first failing vector.
- Reports a pass/fail verdict after a programmed number of vectors.
- Sits at the receive end of the Sch stimulus counter and replaces waveform inspection in the bench.

Parameters:
- W, 4, width of each mout lane.
- IDX_W, 21, width of the stimulus index {cin, a1, a0, m2, m1, m0}.
- NUM_VEC, 2097152, number of vectors in one run (1 to 2**IDX_W).
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; one-cycle pulse.
- in_valid  in  1  a vector and both responses are present this cycle.
- in_idx  in  IDX_W  stimulus index of the current vector.
- dut1_resp  in  4*W+1  {cout, mout3, mout2, mout1, mout0} from implementation 1.
- dut2_resp  in  4*W+1  same packing, from implementation 2.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- vec_cnt  out  IDX_W+1  vectors accepted this run.
- err_cnt  out  CNT_W  mismatching vectors, saturating.
- first_err_vld  out  1  a mismatch has been captured this run.
- first_err_idx  out  IDX_W  in_idx of the first mismatch.
- first_err_diff  out  4*W+1  dut1_resp XOR dut2_resp at the first mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, and every output is 0 (busy, done, pass, vec_cnt, err_cnt, first_err_vld, first_err_idx, first_err_diff).
- Reset asserted mid-run aborts the run immediately; no partial verdict is kept.
- States:
  - IDLE: start=1 -> RUN; clear vec_cnt, err_cnt, first_err_*, pass.
  - RUN: on each clk edge with in_valid=1:
    - vec_cnt += 1.
    - mismatch = (dut1_resp != dut2_resp), comparing all 4*W+1 bits including cout.
    - On mismatch: err_cnt += 1, saturating at 2**CNT_W-1 (holds there).
    - On mismatch with first_err_vld=0: capture in_idx and the XOR, set first_err_vld. Later mismatches never overwrite the capture.
  - RUN -> DONE on the edge that accepts vector number NUM_VEC. That vector is fully counted and compared.
  - DONE: done=1 and pass=(err_cnt==0), both registered; outputs hold. start=1 -> RUN with all counters cleared, as from IDLE.
- Latency: counters and first_err_* update on the same edge that samples in_valid. done and pass become visible on the cycle after the last vector is accepted.
- Ignored inputs:
  - in_valid in IDLE or DONE: nothing changes.
  - start while in RUN: the run continues unchanged.
- Simultaneous events: start and in_valid together in IDLE/DONE → only the transition to RUN happens; that vector is not counted.
- in_idx carries no ordering requirement; the checker does not check for gaps or duplicates.
- vec_cnt is IDX_W+1 bits wide, so NUM_VEC = 2**IDX_W is representable without wrap.
- All state is single-clock; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: rst_n=0 at arbitrary time with nonzero counters → all outputs read 0 in the same cycle, with no clk edge needed.
- Clean run (NUM_VEC=8): start, then 8 valid vectors with dut1_resp==dut2_resp=17'h0A5A5 → next cycle done=1, pass=1, vec_cnt=8, err_cnt=0, first_err_vld=0.
- Mismatch capture (NUM_VEC=8):
  - Stimulus: vector idx 3 has dut2 cout flipped; vector idx 6 has dut2 mout0 = dut1 mout0 ^ 4'h2.
  - Required: err_cnt=2, pass=0, first_err_idx=3, first_err_diff=17'h10000.
- Gaps and ignored inputs:
  - in_valid toggled with idle gaps → vec_cnt counts only in_valid cycles.
  - in_valid pulses in IDLE and DONE → no counter change.
  - start pulse mid-RUN → no restart.
- Saturation (CNT_W=2, NUM_VEC=8): all 8 vectors mismatch → err_cnt=3 (held), first_err_idx=idx of vector 1, pass=0.
- Restart and abort:
  - From DONE with err_cnt=2: start → all counters clear, then a clean 8-vector run gives pass=1.
  - rst_n pulse after 4 vectors → IDLE, vec_cnt=0.

Source files
------------

// File: rtl/sch_resp_checker_if.sv
// Stimulus/response bus between the Sch stimulus source and the response checker.
// The master drives the vector and both implementations' responses; the slave reports the verdict.
interface sch_resp_checker_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned IDX_W = 21,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned RESP_W = 4 * W + 1;

    logic              start;
    logic              in_valid;
    logic [IDX_W-1:0]  in_idx;
    logic [RESP_W-1:0] dut1_resp;
    logic [RESP_W-1:0] dut2_resp;

    logic              busy;
    logic              done;
    logic              pass;
    logic [IDX_W:0]    vec_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              first_err_vld;
    logic [IDX_W-1:0]  first_err_idx;
    logic [RESP_W-1:0] first_err_diff;

    modport master (
        output start, in_valid, in_idx, dut1_resp, dut2_resp,
        input  busy, done, pass, vec_cnt, err_cnt,
        input  first_err_vld, first_err_idx, first_err_diff
    );

    modport slave (
        input  start, in_valid, in_idx, dut1_resp, dut2_resp,
        output busy, done, pass, vec_cnt, err_cnt,
        output first_err_vld, first_err_idx, first_err_diff
    );
endinterface

// File: rtl/sch_resp_checker.sv
// Compares the v1 and v2 Sch adder/mux responses vector by vector, counts mismatches,
// latches the first failing vector and issues a registered pass/fail verdict after NUM_VEC vectors.
module sch_resp_checker #(
    parameter int unsigned W       = 4,
    parameter int unsigned IDX_W   = 21,
    parameter int unsigned NUM_VEC = 2097152,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sch_resp_checker_if.slave  bus
);
    localparam int unsigned RESP_W = 4 * W + 1;
    localparam int unsigned VEC_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] ERR_MAX = '1;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [VEC_W-1:0]    vec_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic                first_err_vld_q;
    logic [IDX_W-1:0]    first_err_idx_q;
    logic [RESP_W-1:0]   first_err_diff_q;

    logic                accept_c;
    logic [RESP_W-1:0]   diff_c;
    logic                mismatch_c;
    logic [VEC_W-1:0]    vec_inc_c;
    logic [CNT_W-1:0]    err_inc_c;
    logic                last_c;

    // Per-vector compare; cout is part of the response word so it is compared too.
    always_comb begin
        accept_c   = (state_q == S_RUN) && bus.in_valid;
        diff_c     = bus.dut1_resp ^ bus.dut2_resp;
        mismatch_c = |diff_c;
        vec_inc_c  = vec_cnt_q + VEC_W'(1);
        err_inc_c  = err_cnt_q;
        if (mismatch_c && (err_cnt_q != ERR_MAX)) begin
            err_inc_c = err_cnt_q + CNT_W'(1);
        end
        last_c     = (vec_inc_c == LAST_VEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            vec_cnt_q        <= '0;
            err_cnt_q        <= '0;
            first_err_vld_q  <= 1'b0;
            first_err_idx_q  <= '0;
            first_err_diff_q <= '0;
        end else begin
            case (state_q)
                // A start wins over a coincident in_valid; that vector is not counted.
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q          <= S_RUN;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        vec_cnt_q        <= '0;
                        err_cnt_q        <= '0;
                        first_err_vld_q  <= 1'b0;
                        first_err_idx_q  <= '0;
                        first_err_diff_q <= '0;
                    end
                end
                S_RUN: begin
                    if (accept_c) begin
                        vec_cnt_q <= vec_inc_c;
                        err_cnt_q <= err_inc_c;
                        if (mismatch_c && !first_err_vld_q) begin
                            first_err_vld_q  <= 1'b1;
                            first_err_idx_q  <= bus.in_idx;
                            first_err_diff_q <= diff_c;
                        end
                        // Verdict uses the error count including the final vector.
                        if (last_c) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_inc_c == '0);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.vec_cnt        = vec_cnt_q;
    assign bus.err_cnt        = err_cnt_q;
    assign bus.first_err_vld  = first_err_vld_q;
    assign bus.first_err_idx  = first_err_idx_q;
    assign bus.first_err_diff = first_err_diff_q;
endmodule
